// File: rtl/score_display.sv
// Pong score keeper: detects out-of-bounds balls per frame, keeps both BCD scores,
// flags the match winner and multiplexes the scores onto a 4-digit seven-segment display.
// Optional winner blinking is built only when SCORE_BLINK_EN is defined.
module score_display #(
  parameter int width       = 800,
  parameter int ball_size   = 10,
  parameter int win_score   = 11,
  parameter int refresh_div = 50000,
  parameter int blink_div   = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frm_tick,
  input  logic [9:0] ball_x,
  input  logic       new_game,
  output logic [7:0] score_l,
  output logic [7:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam logic [10:0] oob_lim  = 11'(width - ball_size + 2);
  localparam logic [7:0]  win_bcd  = {4'(win_score / 10), 4'(win_score % 10)};
  localparam int          rw       = (refresh_div > 1) ? $clog2(refresh_div) : 1;
  localparam logic [rw-1:0] ref_max = rw'(refresh_div - 1);

  logic oob_l, oob_r, prev_l, prev_r, tick_d;
  logic point_l, point_r;
  logic [7:0] inc_l, inc_r;
  logic [rw-1:0] ref_cnt;
  logic [1:0] slot;
  logic wrap_d;
  logic hide_l, hide_r;
  logic [3:0] digit;
  logic blank;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99)
      r = s;
    else if (s[3:0] == 4'd9)
      r = {s[7:4] + 4'd1, 4'd0};
    else
      r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  // Flags are sampled per frame; the previous pair is kept so a point needs a 0->1 edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_l  <= 1'b0;
      oob_r  <= 1'b0;
      prev_l <= 1'b0;
      prev_r <= 1'b0;
      tick_d <= 1'b0;
    end else if (new_game) begin
      oob_l  <= 1'b0;
      oob_r  <= 1'b0;
      prev_l <= 1'b0;
      prev_r <= 1'b0;
      tick_d <= 1'b0;
    end else begin
      tick_d <= frm_tick;
      if (frm_tick) begin
        prev_l <= oob_l;
        prev_r <= oob_r;
        oob_l  <= ({1'b0, ball_x} == 11'd0);
        oob_r  <= ({1'b0, ball_x} > oob_lim);
      end
    end
  end

  assign point_l = tick_d & oob_r & ~prev_r;
  assign point_r = tick_d & oob_l & ~prev_l & ~point_l;
  assign inc_l   = bcd_inc(score_l);
  assign inc_r   = bcd_inc(score_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_l   <= 8'h00;
      score_r   <= 8'h00;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else if (new_game) begin
      score_l   <= 8'h00;
      score_r   <= 8'h00;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else if (!game_over) begin
      if (point_l) begin
        score_l <= inc_l;
        if (inc_l == win_bcd) begin
          game_over <= 1'b1;
          winner    <= 1'b0;
        end
      end else if (point_r) begin
        score_r <= inc_r;
        if (inc_r == win_bcd) begin
          game_over <= 1'b1;
          winner    <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      slot    <= 2'd0;
      wrap_d  <= 1'b0;
    end else begin
      wrap_d <= (ref_cnt == ref_max);
      if (ref_cnt == ref_max) begin
        ref_cnt <= '0;
        slot    <= slot + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + rw'(1);
      end
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int bw = (blink_div > 1) ? $clog2(blink_div) : 1;
  localparam logic [bw-1:0] blink_max = bw'(blink_div - 1);

  logic [bw-1:0] blink_cnt;
  logic blink_off;

  // Held at the visible phase until the match ends, so blinking starts visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (!game_over) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == blink_max) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + bw'(1);
    end
  end

  assign hide_l = game_over & ~winner & blink_off;
  assign hide_r = game_over &  winner & blink_off;
`else
  assign hide_l = 1'b0;
  assign hide_r = 1'b0;
`endif

  always_comb begin
    digit = 4'd0;
    blank = 1'b1;
    case (slot)
      2'd3: begin
        digit = score_l[7:4];
        blank = hide_l | (score_l[7:4] == 4'd0);
      end
      2'd2: begin
        digit = score_l[3:0];
        blank = hide_l;
      end
      2'd1: begin
        digit = score_r[7:4];
        blank = hide_r | (score_r[7:4] == 4'd0);
      end
      default: begin
        digit = score_r[3:0];
        blank = hide_r;
      end
    endcase
  end

  // Display registers load only on the cycle after a refresh wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else if (wrap_d) begin
      an  <= ~(4'b0001 << slot);
      seg <= blank ? 7'h7F : seg_pat(digit);
      dp  <= (slot != 2'd2);
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Randomized self-checking bench for score_display with a rule-level score and display model.
// Blink expectations are included when SCORE_BLINK_EN is defined.
module tb_score_display;

  localparam int RD  = 4;
  localparam int BD  = 8;
  localparam int WIN = 11;
  localparam int LIM = 800 - 10 + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frm_tick;
  logic [9:0] ball_x;
  logic       new_game;
  logic [7:0] score_l, score_r;
  logic       game_over, winner;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  score_display #(
    .width(800), .ball_size(10), .win_score(WIN), .refresh_div(RD), .blink_div(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frm_tick(frm_tick), .ball_x(ball_x), .new_game(new_game),
    .score_l(score_l), .score_r(score_r), .game_over(game_over), .winner(winner),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  // Number of clock edges seen since reset was last released.
  int n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else n <= n + 1;
  end

  int checks = 0;
  int failures = 0;

  int m_l, m_r, m_goedge;
  bit m_go, m_win, m_fl, m_fr;

  logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at n=%0d", tag, got, exp, n);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    return 32'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic modelReset();
    m_l = 0; m_r = 0; m_go = 0; m_win = 0; m_fl = 0; m_fr = 0; m_goedge = 0;
  endtask

  task automatic modelStep(input int x, input bit tick, input bit ng, input int c);
    bit nl, nr, rl, rr;
    if (ng) begin
      m_l = 0; m_r = 0; m_go = 0; m_win = 0; m_fl = 0; m_fr = 0;
    end else if (tick) begin
      nl = (x == 0);
      nr = (x > LIM);
      rl = nl && !m_fl;
      rr = nr && !m_fr;
      m_fl = nl;
      m_fr = nr;
      if (!m_go) begin
        if (rr) begin
          m_l = (m_l < 99) ? m_l + 1 : 99;
          if (m_l == WIN) begin m_go = 1; m_win = 0; m_goedge = c + 2; end
        end else if (rl) begin
          m_r = (m_r < 99) ? m_r + 1 : 99;
          if (m_r == WIN) begin m_go = 1; m_win = 1; m_goedge = c + 2; end
        end
      end
    end
  endtask

  task automatic checkScores(input string tag);
    checkOutput({tag, "_score_l"}, 32'(score_l), to_bcd(m_l));
    checkOutput({tag, "_score_r"}, 32'(score_r), to_bcd(m_r));
    checkOutput({tag, "_game_over"}, 32'(game_over), 32'(m_go));
    checkOutput({tag, "_winner"}, 32'(winner), 32'(m_win));
  endtask

  task automatic applyStimulus(input int x, input bit tick, input bit ng);
    int pre_l, pre_r;
    bit pre_go;
    @(negedge clk);
    pre_l = m_l; pre_r = m_r; pre_go = m_go;
    ball_x = 10'(x);
    frm_tick = tick;
    new_game = ng;
    modelStep(x, tick, ng, n);
    @(negedge clk);
    frm_tick = 1'b0;
    new_game = 1'b0;
    if (!ng) begin
      checkOutput("early_score_l", 32'(score_l), to_bcd(pre_l));
      checkOutput("early_score_r", 32'(score_r), to_bcd(pre_r));
      checkOutput("early_game_over", 32'(game_over), 32'(pre_go));
    end
    @(negedge clk);
    checkScores("step");
  endtask

  task automatic tickThenClear(input int x);
    @(negedge clk);
    ball_x = 10'(x);
    frm_tick = 1'b1;
    @(negedge clk);
    frm_tick = 1'b0;
    new_game = 1'b1;
    modelStep(x, 1'b0, 1'b1, n);
    @(negedge clk);
    new_game = 1'b0;
    @(negedge clk);
    checkScores("pending_clear");
  endtask

  task automatic checkDisplay(input int cycles);
    int k, mm, slot, val, dig;
    bit blank;
    logic [3:0] ea;
    logic [6:0] es;
    logic ed;
    repeat (cycles) begin
      @(negedge clk);
      if (n < RD + 1) begin
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
      end else begin
        k = (n - 1) / RD;
        mm = k * RD + 1;
        slot = k % 4;
        ea = 4'hF;
        ea[slot] = 1'b0;
        ed = (slot != 2);
        val = (slot >= 2) ? m_l : m_r;
        dig = (slot % 2 == 1) ? val / 10 : val % 10;
        blank = (slot % 2 == 1) && (val / 10 == 0);
`ifdef SCORE_BLINK_EN
        if (m_go && (mm - 1 >= m_goedge) && (((mm - 1 - m_goedge) / BD) % 2 == 1) &&
            ((slot >= 2) == (m_win == 0)))
          blank = 1;
`endif
        es = blank ? 7'h7F : segs[dig];
      end
      checkOutput("an", 32'(an), 32'(ea));
      checkOutput("seg", 32'(seg), 32'(es));
      checkOutput("dp", 32'(dp), 32'(ed));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_score_l"}, 32'(score_l), 32'h0);
    checkOutput({tag, "_score_r"}, 32'(score_r), 32'h0);
    checkOutput({tag, "_game_over"}, 32'(game_over), 32'h0);
    checkOutput({tag, "_winner"}, 32'(winner), 32'h0);
    checkOutput({tag, "_seg"}, 32'(seg), 32'h7F);
    checkOutput({tag, "_dp"}, 32'(dp), 32'h1);
    checkOutput({tag, "_an"}, 32'(an), 32'hF);
  endtask

  function automatic int randomX();
    int r;
    r = $urandom_range(0, 4);
    case (r)
      0: return 0;
      1: return $urandom_range(LIM + 1, 1023);
      2: return LIM + $urandom_range(0, 1);
      default: return $urandom_range(1, LIM);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    frm_tick = 1'b0;
    new_game = 1'b0;
    ball_x = 10'd400;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    $display("[TB] startup and idle ball");
    checkDisplay(6 * RD);
    repeat (10) applyStimulus(400, 1'b1, 1'b0);
    checkDisplay(4 * RD);

    $display("[TB] ball held out on the left");
    repeat (3) applyStimulus(0, 1'b1, 1'b0);
    checkOutput("right_once", 32'(score_r), 32'h01);

    $display("[TB] right boundary");
    applyStimulus(LIM, 1'b1, 1'b0);
    applyStimulus(LIM, 1'b1, 1'b0);
    checkOutput("lim_not_out", 32'(score_l), 32'h00);
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(LIM + 1, 1'b1, 1'b0);
    checkOutput("lim_plus_out", 32'(score_l), 32'h01);

    $display("[TB] left player plays to a win");
    for (int i = 0; i < 30 && !m_go; i++) begin
      applyStimulus(400, 1'b1, 1'b0);
      applyStimulus(1000, 1'b1, 1'b0);
    end
    checkOutput("win_score_l", 32'(score_l), 32'h11);
    checkOutput("win_flag", 32'(game_over), 32'h1);
    applyStimulus(400, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 1'b0);
    checkDisplay(8 * RD);

    $display("[TB] new game against scoring tick");
    applyStimulus(1000, 1'b1, 1'b1);
    checkOutput("clear_over", 32'(game_over), 32'h0);
    applyStimulus(0, 1'b1, 1'b0);
    tickThenClear(400);
    tickThenClear(0);
    applyStimulus(0, 1'b1, 1'b0);

    $display("[TB] right player plays to a win");
    for (int i = 0; i < 30 && !m_go; i++) begin
      applyStimulus(400, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 1'b0);
    end
    checkDisplay(8 * RD);

    $display("[TB] random play");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(randomX(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0));
      if (i % 25 == 24) begin
        repeat (RD + 2) @(negedge clk);
        checkDisplay(4 * RD);
      end
    end

    $display("[TB] reset during play");
    applyStimulus(400, 1'b1, 1'b1);
    applyStimulus(400, 1'b1, 1'b0);
    applyStimulus(1000, 1'b1, 1'b0);
    repeat (2 * RD) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("async_reset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    checkDisplay(3 * RD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
